// File: rtl/memory_responder.sv
// Memory responder: issues load/store requests to a 1-cycle synchronous RAM and
// returns in-order completions through a credit-protected response FIFO.
module memory_responder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [4:0]        req_dest_reg,
  input  logic [7:0]        req_data,
  input  logic [7:0]        req_dest_arch_regs,
  input  logic              req_store,
  input  logic              req_valid,
  output logic              req_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [4:0]        resp_dest_reg,
  output logic [7:0]        resp_data,
  output logic [7:0]        resp_dest_arch_regs,
  output logic              resp_store,
  output logic              resp_valid,
  input  logic              resp_ready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef struct packed {
    logic [4:0] dest_reg;
    logic [7:0] data;
    logic [7:0] arch;
    logic       store;
  } entry_t;

  logic             accept_s;
  logic             push_s;
  logic             pop_s;
  logic [CNT_W-1:0] pending_s;
  entry_t           push_entry_s;
  entry_t           head_s;

  logic             inflight_r;
  logic [4:0]       s1_dest_reg_r;
  logic [7:0]       s1_data_r;
  logic [7:0]       s1_arch_r;
  logic             s1_store_r;

  entry_t           fifo_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] occ_r;

  // Credit check counts the in-flight slot so a push can never hit a full FIFO
  always_comb begin
    pending_s = occ_r + CNT_W'(inflight_r);
    if (rst) begin
      req_ready = 1'b0;
    end else if (pending_s < DEPTH_C) begin
      req_ready = 1'b1;
    end else begin
      req_ready = 1'b0;
    end
    accept_s  = req_valid & req_ready;
    mem_en    = accept_s;
    mem_we    = accept_s & req_store;
    mem_addr  = req_addr;
    mem_wdata = req_data;
  end

  // Stage 1: hold request metadata while the RAM read is outstanding
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_r    <= 1'b0;
      s1_dest_reg_r <= 5'd0;
      s1_data_r     <= 8'd0;
      s1_arch_r     <= 8'd0;
      s1_store_r    <= 1'b0;
    end else begin
      inflight_r <= accept_s;
      if (accept_s) begin
        s1_dest_reg_r <= req_dest_reg;
        s1_data_r     <= req_data;
        s1_arch_r     <= req_dest_arch_regs;
        s1_store_r    <= req_store;
      end
    end
  end

  // Stage 2 entry build and FIFO head presentation
  always_comb begin
    push_s                = inflight_r;
    push_entry_s.dest_reg = s1_dest_reg_r;
    push_entry_s.arch     = s1_arch_r;
    push_entry_s.store    = s1_store_r;
    if (s1_store_r) begin
      push_entry_s.data = s1_data_r;
    end else begin
      push_entry_s.data = mem_rdata;
    end
    head_s              = fifo_r[rd_ptr_r];
    resp_valid          = (occ_r != {CNT_W{1'b0}});
    pop_s               = resp_valid & resp_ready;
    resp_dest_reg       = head_s.dest_reg;
    resp_data           = head_s.data;
    resp_dest_arch_regs = head_s.arch;
    resp_store          = head_s.store;
  end

  // Response FIFO storage, pointers and occupancy; entries clear so outputs read 0 in reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_r[i] <= entry_t'(22'd0);
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      occ_r    <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        fifo_r[wr_ptr_r] <= push_entry_s;
        wr_ptr_r         <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + CNT_W'(1);
        2'b01:   occ_r <= occ_r - CNT_W'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Overflow guard on the credit scheme
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(push_s && (occ_r == DEPTH_C)));
      assert (occ_r <= DEPTH_C);
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Randomized bench for memory_responder: RAM model, queue-based reference of
// in-order completions with 2-cycle latency, and credit-based ready expectation.
module tb_memory_responder;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] req_addr;
  logic [4:0]        req_dest_reg;
  logic [7:0]        req_data;
  logic [7:0]        req_dest_arch_regs;
  logic              req_store;
  logic              req_valid;
  logic              req_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata = 8'd0;
  logic [4:0]        resp_dest_reg;
  logic [7:0]        resp_data;
  logic [7:0]        resp_dest_arch_regs;
  logic              resp_store;
  logic              resp_valid;
  logic              resp_ready;

  logic              poke_en = 1'b0;
  logic [15:0]       poke_addr = 16'd0;
  logic [7:0]        poke_data = 8'd0;

  typedef struct {
    logic [4:0] dest;
    logic [7:0] data;
    logic [7:0] arch;
    logic       store;
    int         acc;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  ram     [65536];
  logic [7:0]  ref_mem [65536];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          acc_total = 0;
  logic        done;

  always #5 clk = ~clk;

  memory_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_addr(req_addr), .req_dest_reg(req_dest_reg), .req_data(req_data),
    .req_dest_arch_regs(req_dest_arch_regs), .req_store(req_store),
    .req_valid(req_valid), .req_ready(req_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .resp_dest_reg(resp_dest_reg), .resp_data(resp_data),
    .resp_dest_arch_regs(resp_dest_arch_regs), .resp_store(resp_store),
    .resp_valid(resp_valid), .resp_ready(resp_ready)
  );

  function automatic logic [7:0] fill_val(input int i);
    return 8'(i * 37 + 11);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Synchronous RAM, 1-cycle read latency, with a back door for preloading
  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = fill_val(i);
    forever begin
      @(posedge clk);
      if (poke_en) ram[poke_addr] = poke_data;
      else if (mem_en) begin
        if (mem_we) ram[mem_addr] = mem_wdata;
        else mem_rdata <= ram[mem_addr];
      end
    end
  end

  // Reference model and per-cycle checks, sampled mid-cycle
  initial begin
    logic er, ev, en;
    exp_t e;
    for (int i = 0; i < 65536; i++) ref_mem[i] = fill_val(i);
    forever begin
      @(negedge clk);
      if (poke_en) ref_mem[poke_addr] = poke_data;
      if (rst) begin
        q.delete();
      end else begin
        cyc++;
        er = (q.size() < DEPTH);
        chk("req_ready", req_ready, er);
        ev = 1'b0;
        if (q.size() > 0) ev = (cyc >= q[0].acc + 2);
        chk("resp_valid", resp_valid, ev);
        if (ev) begin
          chk("resp_dest", resp_dest_reg, q[0].dest);
          chk("resp_data", resp_data, q[0].data);
          chk("resp_arch", resp_dest_arch_regs, q[0].arch);
          chk("resp_store", resp_store, q[0].store);
        end
        en = req_valid && er;
        chk("mem_en", mem_en, en);
        chk("mem_we", mem_we, en && req_store);
        if (en) begin
          chk("mem_addr", mem_addr, req_addr);
          if (req_store) chk("mem_wdata", mem_wdata, req_data);
        end
        if (ev && resp_ready) void'(q.pop_front());
        if (en) begin
          e.dest  = req_dest_reg;
          e.arch  = req_dest_arch_regs;
          e.store = req_store;
          if (req_store) begin
            ref_mem[req_addr] = req_data;
            e.data = req_data;
          end else begin
            e.data = ref_mem[req_addr];
          end
          e.acc = cyc;
          q.push_back(e);
          acc_total++;
        end
      end
    end
  end

  task automatic poke(input logic [15:0] a, input logic [7:0] v);
    @(posedge clk); #1;
    poke_en = 1'b1; poke_addr = a; poke_data = v;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  task automatic send(input logic [15:0] a, input logic [4:0] d, input logic [7:0] wd,
                      input logic [7:0] arch, input logic st);
    int n = 0;
    req_addr = a; req_dest_reg = d; req_data = wd;
    req_dest_arch_regs = arch; req_store = st; req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) chk("send_timeout", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    resp_ready = 1'b1;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    chk("drain_empty", q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          a0;
    logic [7:0]  hold_data;
    rst = 1'b1; req_valid = 1'b0; req_addr = 16'd0; req_dest_reg = 5'd0;
    req_data = 8'd0; req_dest_arch_regs = 8'd0; req_store = 1'b0; resp_ready = 1'b1;
    done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_valid", resp_valid, 1'b0);
    rst = 1'b0;
    #1;
    chk("init_ready", req_ready, 1'b1);
    chk("init_valid", resp_valid, 1'b0);
    chk("init_data", resp_data, 8'd0);
    chk("init_dest", resp_dest_reg, 5'd0);

    // single load
    poke(16'h1234, 8'hA5);
    send(16'h1234, 5'd7, 8'h00, 8'h02, 1'b0);
    drain();

    // store then load to the same address, back to back
    send(16'h0080, 5'd1, 8'h3C, 8'h00, 1'b1);
    send(16'h0080, 5'd2, 8'h00, 8'h00, 1'b0);
    drain();
    chk("ram_0080", ram[16'h0080], 8'h3C);

    // streaming loads
    for (int i = 0; i < 8; i++) poke(16'(i), 8'(8'h10 + i));
    for (int i = 0; i < 8; i++) send(16'(i), 5'(i), 8'h00, 8'h80, 1'b0);
    drain();

    // backpressure: only DEPTH requests fit while responses are blocked
    resp_ready = 1'b0;
    a0 = acc_total;
    fork
      begin
        for (int i = 0; i < 6; i++) send(16'(i), 5'(10 + i), 8'h00, 8'h00, 1'b0);
      end
      begin
        repeat (8) @(posedge clk);
        #2;
        chk("bp_accepted", acc_total - a0, 4);
        chk("bp_ready", req_ready, 1'b0);
        chk("bp_head_dest", resp_dest_reg, 5'd10);
        hold_data = resp_data;
        chk("bp_head_data", hold_data, 8'h10);
        repeat (3) @(posedge clk);
        #2;
        chk("bp_hold_dest", resp_dest_reg, 5'd10);
        chk("bp_hold_data", resp_data, hold_data);
        resp_ready = 1'b1;
      end
    join
    drain();

    // randomized mix with toggling response backpressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++)
          send(16'h0300 + 16'($urandom_range(0, 7)), 5'($urandom), 8'($urandom),
               8'($urandom), 1'($urandom));
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          resp_ready = 1'($urandom);
        end
      end
    join
    drain();

    // reset with two queued responses and one in flight
    resp_ready = 1'b0;
    send(16'h0200, 5'd3, 8'h5A, 8'h01, 1'b1);
    send(16'h0201, 5'd4, 8'h00, 8'h00, 1'b0);
    send(16'h0202, 5'd5, 8'h00, 8'h00, 1'b0);
    chk("pre_rst_valid", resp_valid, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async_valid", resp_valid, 1'b0);
    chk("rst_async_ready", req_ready, 1'b0);
    chk("rst_async_data", resp_data, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_ready", req_ready, 1'b1);
    chk("post_rst_valid", resp_valid, 1'b0);
    resp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    send(16'h0200, 5'd6, 8'h00, 8'h00, 1'b0);
    drain();
    chk("ram_kept", ram[16'h0200], 8'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_responder.md
Name: memory_responder

Overview:
- Consumer end of the load/store address pipeline.
- Accepts memory requests (address, destination tags, store data, store flag) over a valid/ready handshake and drives a single-port synchronous RAM with 1-cycle read latency.
- Returns one in-order completion per request (load data or store acknowledge) to writeback over a buffered valid/ready output.

Parameters:
- DEPTH, 4, response FIFO entries; power of two, >= 2. DEPTH >= 3 is needed for one request per cycle sustained.
- ADDR_W, 16, memory address width.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- req_addr  input  ADDR_W  effective address
- req_dest_reg  input  5  physical destination register tag
- req_data  input  8  store data; ignored for loads
- req_dest_arch_regs  input  8  architectural destination mask, passed through
- req_store  input  1  1 = store, 0 = load
- req_valid  input  1  request valid
- req_ready  output  1  request accepted when req_valid & req_ready
- mem_en  output  1  RAM access enable
- mem_we  output  1  RAM write enable
- mem_addr  output  ADDR_W  RAM address
- mem_wdata  output  8  RAM write data
- mem_rdata  input  8  RAM read data, valid the cycle after a read
- resp_dest_reg  output  5  tag of completing request
- resp_data  output  8  load data, or store data for stores
- resp_dest_arch_regs  output  8  passed-through mask
- resp_store  output  1  completion is a store
- resp_valid  output  1  response valid
- resp_ready  input  1  response consumed when resp_valid & resp_ready

Behaviour:
- Accept condition: req_ready = (occ + inflight) < DEPTH. Combinational from registered state only; no same-cycle pop credit. occ is the FIFO occupancy; inflight is the stage-1 valid bit (0/1).
- Issue happens in the accept cycle, combinationally:
  - mem_en = req_valid & req_ready
  - mem_we = mem_en & req_store
  - mem_addr = req_addr, mem_wdata = req_data
  - When mem_en = 0, mem_we is 0. mem_addr and mem_wdata are don't-care.
- Store writes RAM at the accept edge.
- Stage 1, at the accept edge: register inflight=1, dest_reg, dest_arch_regs, store flag, and req_data. With no accept, inflight=0.
- Stage 2, cycle after accept: if inflight, push one entry into the FIFO.
  - Data is the held req_data for stores, mem_rdata for loads.
  - mem_rdata is sampled only in this cycle.
- FIFO output is registered:
  - resp_* show the head entry.
  - resp_valid = (occ != 0).
  - Latency from accept edge to resp_valid is 2 cycles: accepted in cycle N, resp_valid in cycle N+2.
- Ordering: responses are strictly in accept order. No reordering, no dropping.
- Credit guarantees a push never meets a full FIFO. Push to a full FIFO is an assertion failure.
- Simultaneous push and pop: occ unchanged, pointers both advance.
- Pointers wrap modulo DEPTH. occ ranges 0..DEPTH.
- Read-after-write: store accepted in N, load to same address accepted in N+1 returns the stored value.
- Backpressure: resp_ready=0 holds resp_* stable. FIFO fills and req_ready falls when occ+inflight reaches DEPTH.
- Reset (asynchronous, any time):
  - occ=0, pointers=0, inflight=0.
  - resp_valid=0, resp_* data outputs 0.
  - req_ready is 1 once reset is released; it is driven 0 while rst is high.
  - Accepted-but-unreturned requests are discarded. RAM writes already performed are not undone.

Test Plan:
- Single load: RAM[0x1234]=0xA5; request addr=0x1234, dest_reg=7, arch=0x02, store=0, resp_ready=1 -> mem_en=1, mem_we=0 in accept cycle N; resp_valid in N+2 with data=0xA5, dest_reg=7, arch=0x02, resp_store=0; one pulse only.
- Store then load, back-to-back: store 0x3C to 0x0080 (dest_reg=1), then load 0x0080 (dest_reg=2) in the next cycle -> responses in order: (1, 0x3C, store=1) then (2, 0x3C, store=0); RAM[0x0080]=0x3C.
- Streaming: DEPTH=4, 8 consecutive loads of addresses 0..7 holding values 0x10..0x17, resp_ready=1 -> req_ready stays 1 throughout; 8 responses on consecutive cycles, data 0x10..0x17 in order.
- Backpressure: resp_ready=0, 6 loads offered -> exactly 4 accepted, then req_ready=0 and resp_* held stable; raise resp_ready -> the 4 responses drain in order, then the remaining 2 are accepted and returned.
- Wrap and simultaneous push/pop: 20 randomised loads/stores with resp_ready toggling 50% -> scoreboard matches order and data; occ never exceeds 4; no push to a full FIFO.
- Reset mid-operation: assert rst with occ=2 and inflight=1 -> resp_valid=0 immediately without a clock edge; after release, req_ready=1 and no stale responses appear; the store issued before reset remains in RAM.
